// File: rtl/rdma_xmit_if.sv
// rdma_xmit_if: AXI4 write slave channels plus RDMA stream master, bundled for rdma_xmit.
interface rdma_xmit_if #(
    parameter int DATA_WBITS = 512,
    parameter int ADDR_WBITS = 64
);
    localparam int DATA_WBYTS = DATA_WBITS / 8;
    logic [ADDR_WBITS-1:0] S_AXI_AWADDR;
    logic [7:0]            S_AXI_AWLEN;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [DATA_WBITS-1:0] S_AXI_WDATA;
    logic [DATA_WBYTS-1:0] S_AXI_WSTRB;
    logic                  S_AXI_WLAST;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [DATA_WBITS-1:0] AXIS_RDMA_TDATA;
    logic [DATA_WBYTS-1:0] AXIS_RDMA_TKEEP;
    logic                  AXIS_RDMA_TLAST;
    logic                  AXIS_RDMA_TVALID;
    logic                  AXIS_RDMA_TREADY;
    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        output AXIS_RDMA_TDATA, AXIS_RDMA_TKEEP, AXIS_RDMA_TLAST, AXIS_RDMA_TVALID,
        input  AXIS_RDMA_TREADY
    );
    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        input  AXIS_RDMA_TDATA, AXIS_RDMA_TKEEP, AXIS_RDMA_TLAST, AXIS_RDMA_TVALID,
        output AXIS_RDMA_TREADY
    );
endinterface

// File: rtl/rdma_xmit.sv
// rdma_xmit: turns each AXI4 write burst into one UDP/IP RDMA packet (header beat + data beats).
module rdma_xmit #(
    parameter int          DATA_WBITS = 512,
    parameter int          ADDR_WBITS = 64,
    parameter logic [47:0] DST_MAC    = '0,
    parameter logic [47:0] SRC_MAC    = '0,
    parameter logic [31:0] SRC_IP     = '0,
    parameter logic [31:0] DST_IP     = '0,
    parameter logic [15:0] SRC_PORT   = '0,
    parameter logic [15:0] DST_PORT   = '0
) (
    input logic       clk,
    input logic       reset,
    rdma_xmit_if.slave bus
);
    localparam logic [2:0] STARTING = 3'd0, IDLE = 3'd1, SEND_HDR = 3'd2, XFER = 3'd3, SEND_B = 3'd4;
    logic [2:0]            state;
    logic [ADDR_WBITS-1:0] addr;
    logic [7:0]            len, cnt;
    logic                  err;
    logic [15:0]           udp_len, ip_len, csum;
    logic [31:0]           csum_acc, csum_fold;
    logic [511:0]          hdr_be, hdr;
    logic                  last_beat, beat;

    assign udp_len   = 16'd30 + ((16'(len) + 16'd1) << 6);
    assign ip_len    = udp_len + 16'd20;
    assign csum_acc  = 32'h4500 + 32'(ip_len) + 32'h4000 + 32'h4011
                     + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
    assign csum_fold = 32'(csum_acc[15:0]) + 32'(csum_acc[31:16]);
    assign csum      = ~(csum_fold[15:0] + csum_fold[31:16]);

    // Header written in wire order, then byte-swapped so byte 0 lands on TDATA[7:0].
    assign hdr_be = {DST_MAC, SRC_MAC, 16'h0800,
                     16'h4500, ip_len, 16'h0000, 16'h4000, 16'h4011, csum, SRC_IP, DST_IP,
                     SRC_PORT, DST_PORT, udp_len, 16'h0000,
                     64'(addr), len, 104'd0};
    for (genvar i = 0; i < 64; i++) begin : g_swap
        assign hdr[8*i +: 8] = hdr_be[511-8*i -: 8];
    end

    assign last_beat = cnt == len;
    assign beat      = state == XFER && bus.S_AXI_WVALID && bus.AXIS_RDMA_TREADY;

    assign bus.S_AXI_AWREADY    = state == IDLE;
    assign bus.S_AXI_WREADY     = state == XFER && bus.AXIS_RDMA_TREADY;
    assign bus.S_AXI_BVALID     = state == SEND_B;
    assign bus.S_AXI_BRESP      = (state == SEND_B && err) ? 2'b10 : 2'b00;
    assign bus.AXIS_RDMA_TVALID = state == SEND_HDR || (state == XFER && bus.S_AXI_WVALID);
    assign bus.AXIS_RDMA_TLAST  = state == XFER && last_beat;
    assign bus.AXIS_RDMA_TDATA  = state == SEND_HDR ? DATA_WBITS'(hdr) : state == XFER ? bus.S_AXI_WDATA : '0;
    assign bus.AXIS_RDMA_TKEEP  = state == SEND_HDR ? '1 : state == XFER ? bus.S_AXI_WSTRB : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STARTING;
            addr  <= '0;
            len   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                STARTING: state <= IDLE;
                IDLE: if (bus.S_AXI_AWVALID) begin
                    addr  <= bus.S_AXI_AWADDR;
                    len   <= bus.S_AXI_AWLEN;
                    state <= SEND_HDR;
                end
                SEND_HDR: if (bus.AXIS_RDMA_TREADY) begin
                    cnt   <= '0;
                    state <= XFER;
                end
                XFER: if (beat) begin
                    cnt <= cnt + 8'd1;
                    if (bus.S_AXI_WLAST != last_beat) err <= 1'b1;
                    if (last_beat) state <= SEND_B;
                end
                SEND_B: if (bus.S_AXI_BREADY) begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= STARTING;
            endcase
        end
    end
endmodule

// File: tb/tb_rdma_xmit.sv
// tb_rdma_xmit: table-driven bursts with hand-computed header fields, plus reset and B-stall sequences.
module tb_rdma_xmit;
    localparam int          DW   = 512;
    localparam int          DB   = DW / 8;
    localparam logic [47:0] DMAC = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] SMAC = 48'h112233445566;
    localparam logic [31:0] SIP  = 32'hC0A80001;
    localparam logic [31:0] DIP  = 32'hC0A80002;
    localparam logic [15:0] SP   = 16'h1234;
    localparam logic [15:0] DP   = 16'h12B7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rdma_xmit_if #(.DATA_WBITS(DW), .ADDR_WBITS(64)) bus ();
    rdma_xmit #(.DATA_WBITS(DW), .ADDR_WBITS(64), .DST_MAC(DMAC), .SRC_MAC(SMAC),
                .SRC_IP(SIP), .DST_IP(DIP), .SRC_PORT(SP), .DST_PORT(DP))
        dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        int          wlast_at;
        bit          stall;
        int          bdly;
        logic [15:0] udp;
        logic [15:0] ip;
        logic [15:0] csum;
        logic [1:0]  bresp;
    } rec_t;

    rec_t tbl[5];
    rec_t after_rst;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] exp_hdr(input rec_t r);
        logic [7:0]   b[64];
        logic [511:0] v;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]     = DMAC[47-8*i -: 8];
            b[6 + i] = SMAC[47-8*i -: 8];
        end
        b[12] = 8'h08; b[14] = 8'h45;
        b[16] = r.ip[15:8]; b[17] = r.ip[7:0];
        b[20] = 8'h40; b[22] = 8'h40; b[23] = 8'h11;
        b[24] = r.csum[15:8]; b[25] = r.csum[7:0];
        for (int i = 0; i < 4; i++) begin
            b[26 + i] = SIP[31-8*i -: 8];
            b[30 + i] = DIP[31-8*i -: 8];
        end
        b[34] = SP[15:8]; b[35] = SP[7:0]; b[36] = DP[15:8]; b[37] = DP[7:0];
        b[38] = r.udp[15:8]; b[39] = r.udp[7:0];
        for (int i = 0; i < 8; i++) b[42 + i] = r.addr[63-8*i -: 8];
        b[50] = r.len;
        for (int i = 0; i < 64; i++) v[8*i +: 8] = b[i];
        return v;
    endfunction

    // Ones-complement sum over the received IPv4 header; a correct checksum makes it 0xFFFF.
    function automatic logic [15:0] ip_sum(input logic [511:0] h);
        logic [31:0] s = 0;
        for (int k = 0; k < 10; k++) s += {16'd0, h[8*(14+2*k) +: 8], h[8*(15+2*k) +: 8]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return s[15:0];
    endfunction

    task automatic run_burst(input rec_t r, input string tag);
        logic [DW-1:0]  wd;
        logic [DB-1:0]  ws;
        logic [511:0]   h;
        logic [63:0]    a;
        int             b, cyc;
        bit             done, acc;
        @(negedge clk);
        bus.S_AXI_AWADDR  = r.addr;
        bus.S_AXI_AWLEN   = r.len;
        bus.S_AXI_AWVALID = 1'b1;
        #1 chk({tag, ".awready"}, bus.S_AXI_AWREADY, 1);
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        cyc = 0;
        done = 0;
        h = '0;
        while (!done && cyc < 100) begin
            bus.AXIS_RDMA_TREADY = r.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk({tag, ".hdr_tvalid"}, bus.AXIS_RDMA_TVALID, 1);
            chk({tag, ".hdr_tlast"}, bus.AXIS_RDMA_TLAST, 0);
            chk({tag, ".hdr_tkeep"}, bus.AXIS_RDMA_TKEEP, {DB{1'b1}});
            chk({tag, ".hdr_tdata"}, bus.AXIS_RDMA_TDATA, exp_hdr(r));
            chk({tag, ".hdr_wready"}, bus.S_AXI_WREADY, 0);
            h = bus.AXIS_RDMA_TDATA;
            done = bus.AXIS_RDMA_TREADY;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!done) chk({tag, ".hdr_timeout"}, 0, 1);
        for (int i = 0; i < 8; i++) a[63-8*i -: 8] = h[8*(42+i) +: 8];
        chk({tag, ".addr"}, a, r.addr);
        chk({tag, ".len_byte"}, h[8*50 +: 8], r.len);
        chk({tag, ".udp_len"}, {h[8*38 +: 8], h[8*39 +: 8]}, r.udp);
        chk({tag, ".ip_len"}, {h[8*16 +: 8], h[8*17 +: 8]}, r.ip);
        chk({tag, ".csum_valid"}, ip_sum(h), 16'hFFFF);
        b = 0;
        cyc = 0;
        bus.S_AXI_WVALID = 1'b0;
        while (b <= int'(r.len) && cyc < 5000) begin
            if (!bus.S_AXI_WVALID) begin
                for (int k = 0; k < DW / 32; k++) wd[32*k +: 32] = $urandom;
                ws = {$urandom, $urandom};
                bus.S_AXI_WDATA  = wd;
                bus.S_AXI_WSTRB  = ws;
                bus.S_AXI_WLAST  = b == r.wlast_at;
                bus.S_AXI_WVALID = r.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            bus.AXIS_RDMA_TREADY = r.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk({tag, ".wready"}, bus.S_AXI_WREADY, bus.AXIS_RDMA_TREADY);
            chk({tag, ".d_tvalid"}, bus.AXIS_RDMA_TVALID, bus.S_AXI_WVALID);
            if (bus.S_AXI_WVALID) begin
                chk({tag, ".d_tdata"}, bus.AXIS_RDMA_TDATA, wd);
                chk({tag, ".d_tkeep"}, bus.AXIS_RDMA_TKEEP, ws);
                chk({tag, ".d_tlast"}, bus.AXIS_RDMA_TLAST, b == int'(r.len));
            end
            acc = bus.S_AXI_WVALID && bus.AXIS_RDMA_TREADY;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc) begin
                b++;
                bus.S_AXI_WVALID = 1'b0;
            end
        end
        chk({tag, ".beats"}, b, int'(r.len) + 1);
        bus.AXIS_RDMA_TREADY = 1'b1;
        for (int k = 0; k < r.bdly; k++) begin
            bus.S_AXI_BREADY = 1'b0;
            #1;
            chk({tag, ".bvalid_hold"}, bus.S_AXI_BVALID, 1);
            chk({tag, ".awready_hold"}, bus.S_AXI_AWREADY, 0);
            chk({tag, ".tvalid_in_b"}, bus.AXIS_RDMA_TVALID, 0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.S_AXI_BREADY = 1'b1;
        #1;
        chk({tag, ".bvalid"}, bus.S_AXI_BVALID, 1);
        chk({tag, ".bresp"}, bus.S_AXI_BRESP, r.bresp);
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        #1;
        chk({tag, ".bvalid_clr"}, bus.S_AXI_BVALID, 0);
        chk({tag, ".idle"}, bus.S_AXI_AWREADY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{64'h1234_5678_9ABC_0000, 8'd3,   3,   1'b0, 0,  16'h011E, 16'h0132, 16'hB867, 2'b00};
        tbl[1] = '{64'h0000_0000_0000_1000, 8'd0,   0,   1'b0, 0,  16'h005E, 16'h0072, 16'hB927, 2'b00};
        tbl[2] = '{64'hFEDC_BA98_7654_3210, 8'd15,  15,  1'b1, 0,  16'h041E, 16'h0432, 16'hB567, 2'b00};
        tbl[3] = '{64'h0000_0000_0000_0040, 8'd4,   1,   1'b0, 0,  16'h015E, 16'h0172, 16'hB827, 2'b10};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFC0, 8'd255, 255, 1'b0, 10, 16'h401E, 16'h4032, 16'h7967, 2'b00};
        after_rst = '{64'hA5A5_0000_0000_0080, 8'd7, 7, 1'b0, 0, 16'h021E, 16'h0232, 16'hB767, 2'b00};
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0; bus.AXIS_RDMA_TREADY = 1'b1;
        #1;
        chk("rst.awready", bus.S_AXI_AWREADY, 0);
        chk("rst.tvalid", bus.AXIS_RDMA_TVALID, 0);
        chk("rst.bvalid", bus.S_AXI_BVALID, 0);
        chk("rst.tdata", bus.AXIS_RDMA_TDATA, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst.starting", bus.S_AXI_AWREADY, 0);
        for (int t = 0; t < 5; t++) run_burst(tbl[t], $sformatf("vec%0d", t));

        // Reset pulsed while beat index 2 of an AWLEN=7 burst is on the bus.
        @(negedge clk);
        bus.S_AXI_AWADDR = 64'h0000_0000_0000_0700; bus.S_AXI_AWLEN = 8'd7; bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WDATA = {16{32'hDEAD_BEEF}}; bus.S_AXI_WSTRB = '1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mid.tvalid", bus.AXIS_RDMA_TVALID, 1);
        chk("mid.tlast", bus.AXIS_RDMA_TLAST, 0);
        reset = 1'b1;
        #1;
        chk("mid.rst_tvalid", bus.AXIS_RDMA_TVALID, 0);
        chk("mid.rst_wready", bus.S_AXI_WREADY, 0);
        chk("mid.rst_tlast", bus.AXIS_RDMA_TLAST, 0);
        chk("mid.rst_tdata", bus.AXIS_RDMA_TDATA, 0);
        chk("mid.rst_tkeep", bus.AXIS_RDMA_TKEEP, 0);
        chk("mid.rst_awready", bus.S_AXI_AWREADY, 0);
        chk("mid.rst_bvalid", bus.S_AXI_BVALID, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.S_AXI_WVALID = 1'b0;
        #1 chk("mid.awready_1st", bus.S_AXI_AWREADY, 0);
        @(posedge clk);
        @(negedge clk);
        #1 chk("mid.awready_2nd", bus.S_AXI_AWREADY, 1);
        chk("mid.tvalid_idle", bus.AXIS_RDMA_TVALID, 0);
        run_burst(after_rst, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
